bp_me_host_fwd_arbiter: RTL
===========================

BP_ME_HOST_FWD_ARBITER -- requirements
Module: bp_me_host_fwd_arbiter

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg, the processor configuration that supplies all BedRock widths.
REQ-002 SHALL have parameter num_req_p, default 4, the number of requesters sharing the host device port (2..16).
REQ-003 SHALL have parameter timeout_p, default 1024, the response watchdog limit in cycles.
REQ-004 clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset_n_i  input  1  reset, asynchronous and active-low.
REQ-006 req_fwd_header_i  input  num_req_p x mem_fwd_header_width_lp  per-requester forward header.
REQ-007 req_fwd_data_i  input  num_req_p x bedrock_fill_width_p  per-requester forward data.
REQ-008 req_fwd_v_i  input  num_req_p  per-requester forward valid.
REQ-009 req_fwd_ready_and_o  output  num_req_p  per-requester forward ready (ready-and handshake).
REQ-010 req_rev_header_o  output  mem_rev_header_width_lp  response header, broadcast to all requesters.
REQ-011 req_rev_data_o  output  bedrock_fill_width_p  response data, broadcast.
REQ-012 req_rev_v_o  output  num_req_p  one-hot response valid to the owning requester.
REQ-013 req_rev_ready_and_i  input  num_req_p  per-requester response ready.
REQ-014 mem_fwd_header_o / mem_fwd_data_o / mem_fwd_v_o  output  header/fill/1  forward toward host device.
REQ-015 mem_fwd_ready_and_i  input  1  host forward ready.
REQ-016 mem_rev_header_i / mem_rev_data_i / mem_rev_v_i  input  header/fill/1  response from host device.
REQ-017 mem_rev_ready_and_o  output  1  response ready toward host.
REQ-018 timeout_o  output  1  sticky watchdog error flag.

Function
REQ-019 SHALL implement states e_idle, e_send, e_wait, e_resp; exactly one transaction outstanding.
REQ-020 e_idle: round-robin grant among req_fwd_v_i; req_fwd_ready_and_o asserted only to the granted requester; on handshake capture header/data and owner index, go e_send; no request -> stay.
REQ-021 Round-robin priority SHALL start at index (last owner+1) mod num_req_p; pointer updates only on completion in e_resp.
REQ-022 e_send: mem_fwd_v_o=1 from captured registers (first asserted the cycle after acceptance); on mem_fwd_ready_and_i go e_wait.
REQ-023 e_wait: mem_rev_ready_and_o=1; on mem_rev_v_i capture header/data, go e_resp; mem_rev_ready_and_o SHALL be 0 in all other states.
REQ-024 e_resp: req_rev_v_o one-hot at owner; on req_rev_ready_and_i[owner] go e_idle; ready from non-owners ignored.
REQ-025 All req_fwd_ready_and_o SHALL be 0 outside e_idle; valids held by requesters persist.
REQ-026 Watchdog counter SHALL clear on entry to e_wait, increment each e_wait cycle, saturate; reaching timeout_p sets timeout_o until reset; FSM continues waiting.
REQ-027 Request arriving in the cycle e_resp completes SHALL NOT be granted until the following cycle (e_idle).
REQ-028 Outputs SHALL be registered-state driven; no combinational path from mem_rev_v_i to req_rev_v_o.

Reset
REQ-029 Asserting reset_n_i low SHALL asynchronously force e_idle, rr pointer 0, watchdog 0, timeout_o 0, all valid/ready outputs 0, including mid-transaction; captured data registers need not reset.
REQ-030 First grant after reset release SHALL favour index 0.

Structure
REQ-031 State enum bp_me_host_arb_state_e SHALL live in bp_me_pkg.
REQ-032 Grant logic SHALL use sub-module bsg_arb_round_robin; BedRock structs via the standard bedrock declare macros.

Verification
REQ-033 Single request from req 2, host ready, rev after 3 cycles -> mem_fwd_v_o cycle 1, req_rev_v_o=4'b0100 with identical header/data.
REQ-034 All 4 requesting continuously -> owners 0,1,2,3,0 in order, one transaction at a time.
REQ-035 Host holds mem_fwd_ready_and_i low 10 cycles -> mem_fwd_v_o and payload stable throughout; no grants issued.
REQ-036 Host withholds response 1024 cycles (timeout_p=1024) -> timeout_o rises at cycle 1024, stays high after late response is delivered.
REQ-037 reset_n_i pulsed low during e_wait -> outputs zero immediately, next grant to req 0.
REQ-038 Owner holds req_rev_ready_and_i low while req 3 asserts ready -> response held, no completion.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared types for the host forward arbiter: configuration selector, BedRock
// memory header layout, width helpers and the arbiter FSM state encoding.
package bp_me_pkg;

   typedef enum logic [0:0] {
      e_bp_default_cfg = 1'b0
   } bp_params_e;

   typedef struct packed {
      logic [3:0]  msg_type;
      logic [39:0] addr;
      logic [2:0]  size;
      logic [16:0] payload;
   } bp_bedrock_mem_header_s;

   typedef enum logic [1:0] {
      e_idle = 2'd0,
      e_send = 2'd1,
      e_wait = 2'd2,
      e_resp = 2'd3
   } bp_me_host_arb_state_e;

   function automatic int bp_mem_header_width(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return $bits(bp_bedrock_mem_header_s);
         default:          return $bits(bp_bedrock_mem_header_s);
      endcase
   endfunction

   function automatic int bp_fill_width(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 64;
         default:          return 64;
      endcase
   endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Combinational round-robin picker: the first requester at or after i_ptr
// (wrapping) wins; one-hot grant plus binary tag.
module bsg_arb_round_robin #(
   parameter int width_p = 4,
   localparam int tag_width_lp = $clog2(width_p)
) (
   input  logic [width_p-1:0]      i_reqs,
   input  logic [tag_width_lp-1:0] i_ptr,
   output logic [width_p-1:0]      o_grant,
   output logic [tag_width_lp-1:0] o_tag,
   output logic                    o_v
);

   int                      w_sum;
   logic [tag_width_lp-1:0] w_idx;

   always_comb begin
      // NOTE: every output gets a default first so this block never infers a latch.
      o_grant = '0;
      o_tag   = '0;
      o_v     = 1'b0;
      w_sum   = 0;
      w_idx   = '0;
      // Walk from lowest to highest priority; the last hit (offset 0 side) wins.
      for (int off = width_p - 1; off >= 0; off--) begin
         w_sum = int'(i_ptr) + off;
         if (w_sum >= width_p) w_sum = w_sum - width_p;
         w_idx = tag_width_lp'(w_sum);
         if (i_reqs[w_idx]) begin
            o_grant        = '0;
            o_grant[w_idx] = 1'b1;
            o_tag          = w_idx;
            o_v            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bp_me_host_fwd_arbiter.sv
// Shares one host device port among num_req_p requesters, one transaction at a
// time, with round-robin fairness and a sticky response watchdog.
module bp_me_host_fwd_arbiter
   import bp_me_pkg::*;
#(
   parameter bp_params_e bp_params_p = e_bp_default_cfg,
   parameter int num_req_p = 4,
   parameter int timeout_p = 1024,
   localparam int mem_fwd_header_width_lp = bp_mem_header_width(bp_params_p),
   localparam int mem_rev_header_width_lp = bp_mem_header_width(bp_params_p),
   localparam int bedrock_fill_width_p    = bp_fill_width(bp_params_p),
   localparam int owner_width_lp          = $clog2(num_req_p),
   localparam int wd_width_lp             = $clog2(timeout_p + 1)
) (
   input  logic                                             clk_i,
   input  logic                                             reset_n_i,
   input  logic [num_req_p-1:0][mem_fwd_header_width_lp-1:0] req_fwd_header_i,
   input  logic [num_req_p-1:0][bedrock_fill_width_p-1:0]    req_fwd_data_i,
   input  logic [num_req_p-1:0]                             req_fwd_v_i,
   output logic [num_req_p-1:0]                             req_fwd_ready_and_o,
   output logic [mem_rev_header_width_lp-1:0]               req_rev_header_o,
   output logic [bedrock_fill_width_p-1:0]                  req_rev_data_o,
   output logic [num_req_p-1:0]                             req_rev_v_o,
   input  logic [num_req_p-1:0]                             req_rev_ready_and_i,
   output logic [mem_fwd_header_width_lp-1:0]               mem_fwd_header_o,
   output logic [bedrock_fill_width_p-1:0]                  mem_fwd_data_o,
   output logic                                             mem_fwd_v_o,
   input  logic                                             mem_fwd_ready_and_i,
   input  logic [mem_rev_header_width_lp-1:0]               mem_rev_header_i,
   input  logic [bedrock_fill_width_p-1:0]                  mem_rev_data_i,
   input  logic                                             mem_rev_v_i,
   output logic                                             mem_rev_ready_and_o,
   output logic                                             timeout_o
);

   localparam logic [wd_width_lp-1:0] wd_max_lp = wd_width_lp'(timeout_p);

   bp_me_host_arb_state_e               r_state;
   logic [owner_width_lp-1:0]           r_owner;
   logic [owner_width_lp-1:0]           r_rr_ptr;
   logic [wd_width_lp-1:0]              r_wd_cnt;
   logic                                r_timeout;
   logic                                r_mem_fwd_v;
   logic                                r_mem_rev_ready;
   logic                                r_resp;
   logic [mem_fwd_header_width_lp-1:0]  r_fwd_header;
   logic [bedrock_fill_width_p-1:0]     r_fwd_data;
   logic [mem_rev_header_width_lp-1:0]  r_rev_header;
   logic [bedrock_fill_width_p-1:0]     r_rev_data;

   logic [num_req_p-1:0]                w_grant;
   logic [owner_width_lp-1:0]           w_grant_tag;
   logic                                w_grant_v;
   logic                                w_accept;
   logic [owner_width_lp-1:0]           w_next_ptr;
   logic [num_req_p-1:0]                w_owner_onehot;

   bsg_arb_round_robin #(
      .width_p (num_req_p)
   ) u_arb (
      .i_reqs  (req_fwd_v_i),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_tag   (w_grant_tag),
      .o_v     (w_grant_v)
   );

   assign w_accept   = (r_state == e_idle) && w_grant_v;
   assign w_next_ptr = (r_owner == owner_width_lp'(num_req_p - 1)) ? '0 : r_owner + 1'b1;

   always_comb begin
      w_owner_onehot          = '0;
      w_owner_onehot[r_owner] = 1'b1;
   end

   // Reset gates ready so no handshake can appear while reset is held.
   assign req_fwd_ready_and_o = (r_state == e_idle && reset_n_i) ? w_grant : '0;
   assign req_rev_v_o         = r_resp ? w_owner_onehot : '0;
   assign req_rev_header_o    = r_rev_header;
   assign req_rev_data_o      = r_rev_data;
   assign mem_fwd_header_o    = r_fwd_header;
   assign mem_fwd_data_o      = r_fwd_data;
   assign mem_fwd_v_o         = r_mem_fwd_v;
   assign mem_rev_ready_and_o = r_mem_rev_ready;
   assign timeout_o           = r_timeout;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state         <= e_idle;
         r_owner         <= '0;
         r_rr_ptr        <= '0;
         r_wd_cnt        <= '0;
         r_timeout       <= 1'b0;
         r_mem_fwd_v     <= 1'b0;
         r_mem_rev_ready <= 1'b0;
         r_resp          <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         case (r_state)
            e_idle: if (w_accept) begin
               r_owner     <= w_grant_tag;
               r_mem_fwd_v <= 1'b1;
               r_state     <= e_send;
            end
            e_send: if (mem_fwd_ready_and_i) begin
               r_mem_fwd_v     <= 1'b0;
               r_mem_rev_ready <= 1'b1;
               r_wd_cnt        <= '0;
               r_state         <= e_wait;
            end
            e_wait: begin
               if (r_wd_cnt != wd_max_lp) r_wd_cnt <= r_wd_cnt + 1'b1;
               if (r_wd_cnt == wd_max_lp - 1'b1) r_timeout <= 1'b1;
               if (mem_rev_v_i) begin
                  r_mem_rev_ready <= 1'b0;
                  r_resp          <= 1'b1;
                  r_state         <= e_resp;
               end
            end
            e_resp: if (req_rev_ready_and_i[r_owner]) begin
               r_resp   <= 1'b0;
               r_rr_ptr <= w_next_ptr;
               r_state  <= e_idle;
            end
            default: r_state <= e_idle;
         endcase
      end
   end

   // NOTE: payload registers carry no reset; they are only read while a valid qualifies them.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_fwd_header <= req_fwd_header_i[w_grant_tag];
         r_fwd_data   <= req_fwd_data_i[w_grant_tag];
      end
      if (r_state == e_wait && mem_rev_v_i) begin
         r_rev_header <= mem_rev_header_i;
         r_rev_data   <= mem_rev_data_i;
      end
   end

endmodule
